mem_responder: RTL and testbench
================================

# mem_responder

Synthesizable multi-channel memory responder that sits on the memory side of the GPU's external memory interface, serving the channels driven by the program or data memory controller. It owns a single-ported backing array of 2^ADDR_BITS words and arbitrates per-channel read/write requests round-robin, one array access per cycle. Each response arrives after a configurable latency and is held until the requester drops its valid. It replaces the behavioural testbench memory and serves as the on-chip memory in FPGA builds; a load port preloads program and data before `start`.

## Interface
- ADDR_BITS, 8: address width; the array holds 2^ADDR_BITS words.
- DATA_BITS, 8: word width (16 for program memory).
- CHANNELS, 4: number of independent request channels; must match the controller's NUM_CHANNELS.
- LATENCY, 2: extra cycles between the array access and the ready assertion; valid range 0..15.
- WRITE_ENABLE, 1: 0 makes the block read-only (program memory).
- clk  in  1  single clock, all logic on posedge.
- reset  in  1  synchronous, active-low (0 = reset), sampled on posedge clk.
- read_valid  in  [CHANNELS]  per-channel read request, held high until read_ready is seen.
- read_address  in  [CHANNELS][ADDR_BITS]  read address, stable while read_valid is high.
- read_ready  out  [CHANNELS]  read response valid.
- read_data  out  [CHANNELS][DATA_BITS]  read result, stable while read_ready is high.
- write_valid  in  [CHANNELS]  per-channel write request.
- write_address  in  [CHANNELS][ADDR_BITS]  write address.
- write_data  in  [CHANNELS][DATA_BITS]  write data.
- write_ready  out  [CHANNELS]  write acknowledged.
- load_enable  in  1  backdoor write strobe.
- load_address  in  ADDR_BITS  backdoor address.
- load_data  in  DATA_BITS  backdoor data.

## Operation
- Each channel has its own FSM: IDLE -> QUEUED -> BUSY -> DONE -> IDLE.
- IDLE: if read_valid is sampled high, capture the address, set op=READ and go to QUEUED. Otherwise, if write_valid is high, capture the address and data, set op=WRITE and go to QUEUED.
- When read and write are both high, the read is serviced first. The write is taken in a later IDLE cycle.
- QUEUED: wait for the grant. The arbiter issues at most one grant per cycle among the QUEUED channels. The search starts at rr_ptr and wraps modulo CHANNELS. After each grant, rr_ptr becomes the granted index + 1, wrapping at CHANNELS.
- Grant cycle:
  - READ: the array word is latched into the channel's read_data register.
  - WRITE: the array is written when WRITE_ENABLE=1. When WRITE_ENABLE=0 the write is acknowledged but has no effect.
  - The channel loads its 4-bit latency counter with LATENCY and goes to BUSY.
- BUSY: the counter decrements each cycle. When the counter is 0, the channel goes to DONE.
- DONE: the matching ready output is high. It stays high while the matching valid is high, and drops the cycle after valid is sampled low; the FSM then returns to IDLE.
  - If valid was already low on entry to DONE, ready is high for exactly one cycle.
- Once granted, a request is never aborted. An early valid drop does not roll back a write.
- load_enable takes priority over arbitration: in a cycle with load_enable=1, no grant is issued and the array is written with load_data at load_address. QUEUED channels simply wait.
- The array contents are not reset.
- Reset (reset=0):
  - All FSMs go to IDLE.
  - All read_ready and write_ready outputs go to 0.
  - All read_data outputs go to 0.
  - rr_ptr goes to 0.
  - QUEUED requests are discarded.
  - A write granted in the same cycle that reset is sampled is suppressed.

## Timing
- Request first sampled at edge T -> channel QUEUED during cycle T+1.
- Uncontended grant at T+1 -> ready rises at T+2+LATENCY (T+4 at the default).
- Contention: each extra cycle spent in QUEUED delays ready by one cycle. With N simultaneous requests, the grant for the k-th channel in round-robin order (k = 0..N-1) occurs at T+1+k.
- The earliest a channel can accept its next request is the cycle after it returns to IDLE.
- Outputs are registered; there is no combinational path from inputs to outputs.
- Read-after-write from different channels returns the new data if the write's grant cycle precedes the read's grant cycle.

## Test plan
- Preload: load 0x5A at 0x10; ch0 reads 0x10 at T -> read_ready[0]=1 at T+4 with read_data[0]=0x5A, held until read_valid drops, then low one cycle later.
- ch1 writes 0x33 to 0x20; once write_ready[1] is seen, ch2 reads 0x20 -> 0x33.
- All 4 channels issue reads in the same cycle with rr_ptr=0 -> grants in order 0,1,2,3; readies at T+4, T+5, T+6, T+7; rr_ptr=0 afterwards.
- WRITE_ENABLE=0: ch0 writes 0xFF to 0x10 -> write_ready asserted; a later read returns the preloaded 0x5A.
- ch3 asserts read and write together -> read_ready first; write_ready follows after read_valid drops and the channel re-samples; load_enable held high for 3 cycles delays the grant by exactly 3 cycles.
- Reset driven low while ch0 is in BUSY and ch1 is QUEUED -> all readies and read_data are 0 on the next cycle; ch1's queued write never reaches the array.

Source files
------------

// File: rtl/mem_responder.sv
// Multi-channel memory responder: per-channel request FSMs sharing one
// single-ported array through a round-robin arbiter, with a backdoor load port.
module mem_responder #(
  parameter int ADDR_BITS    = 8,
  parameter int DATA_BITS    = 8,
  parameter int CHANNELS     = 4,
  parameter int LATENCY      = 2,
  parameter int WRITE_ENABLE = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [CHANNELS-1:0]                 read_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  read_address,
  output logic [CHANNELS-1:0]                 read_ready,
  output logic [CHANNELS-1:0][DATA_BITS-1:0]  read_data,
  input  logic [CHANNELS-1:0]                 write_valid,
  input  logic [CHANNELS-1:0][ADDR_BITS-1:0]  write_address,
  input  logic [CHANNELS-1:0][DATA_BITS-1:0]  write_data,
  output logic [CHANNELS-1:0]                 write_ready,
  input  logic                                load_enable,
  input  logic [ADDR_BITS-1:0]                load_address,
  input  logic [DATA_BITS-1:0]                load_data,
  output logic [CHANNELS-1:0][1:0]            state_dbg
);

  localparam int PTR_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    QUEUED = 2'd1,
    BUSY   = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t                            state_q [CHANNELS];
  state_t                            state_d [CHANNELS];
  logic [CHANNELS-1:0]               op_q, op_d;       // 1 = write
  logic [CHANNELS-1:0][ADDR_BITS-1:0] addr_q, addr_d;
  logic [CHANNELS-1:0][DATA_BITS-1:0] wdata_q, wdata_d;
  logic [CHANNELS-1:0][3:0]          cnt_q, cnt_d;

  logic [PTR_W-1:0]     rr_ptr;
  logic [PTR_W-1:0]     grant_idx;
  logic                 grant_valid;
  logic                 grant_write;

  logic [DATA_BITS-1:0] mem [2**ADDR_BITS];

  // Round-robin search from rr_ptr; the load port steals the array cycle.
  always_comb begin
    int idx;
    idx         = 0;
    grant_valid = 1'b0;
    grant_idx   = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= CHANNELS) idx = idx - CHANNELS;
      if (!grant_valid && !load_enable && state_q[idx] == QUEUED) begin
        grant_valid = 1'b1;
        grant_idx   = PTR_W'(idx);
      end
    end
  end

  assign grant_write = op_q[grant_idx];

  // Handshake: a requester holds valid (and its address/data) until it sees
  // ready; ready then stays high until valid is sampled low, after which the
  // channel returns to IDLE. A read beats a write raised in the same cycle.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    cnt_d   = cnt_q;
    for (int i = 0; i < CHANNELS; i++) begin
      case (state_q[i])
        IDLE: begin
          if (read_valid[i]) begin
            op_d[i]    = 1'b0;
            addr_d[i]  = read_address[i];
            state_d[i] = QUEUED;
          end else if (write_valid[i]) begin
            op_d[i]    = 1'b1;
            addr_d[i]  = write_address[i];
            wdata_d[i] = write_data[i];
            state_d[i] = QUEUED;
          end
        end
        QUEUED: begin
          if (grant_valid && int'(grant_idx) == i) begin
            cnt_d[i]   = 4'(LATENCY);
            state_d[i] = BUSY;
          end
        end
        BUSY: begin
          if (cnt_q[i] == 4'd0) state_d[i] = DONE;
          else                  cnt_d[i]   = cnt_q[i] - 4'd1;
        end
        DONE: begin
          if (op_q[i] ? !write_valid[i] : !read_valid[i]) state_d[i] = IDLE;
        end
        default: state_d[i] = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < CHANNELS; i++) state_q[i] <= IDLE;
      op_q    <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      rr_ptr    <= '0;
      read_data <= '0;
    end else if (grant_valid) begin
      rr_ptr <= (grant_idx == PTR_W'(CHANNELS - 1)) ? '0 : grant_idx + PTR_W'(1);
      if (!grant_write) read_data[grant_idx] <= mem[addr_q[grant_idx]];
    end
  end

  // Array contents survive reset; only a granted write is gated by it.
  always_ff @(posedge clk) begin
    if (load_enable) begin
      mem[load_address] <= load_data;
    end else if (reset && grant_valid && grant_write && (WRITE_ENABLE != 0)) begin
      mem[addr_q[grant_idx]] <= wdata_q[grant_idx];
    end
  end

  always_comb begin
    read_ready  = '0;
    write_ready = '0;
    state_dbg   = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      read_ready[i]  = (state_q[i] == DONE) && !op_q[i];
      write_ready[i] = (state_q[i] == DONE) && op_q[i];
      state_dbg[i]   = state_q[i];
    end
  end

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder: a writable and a read-only instance share
// the same stimulus; expected values are hand-computed per step.
module tb_mem_responder;

  logic            clk = 1'b0;
  logic            reset = 1'b0;
  logic [3:0]      read_valid = '0;
  logic [3:0][7:0] read_address = '0;
  logic [3:0]      write_valid = '0;
  logic [3:0][7:0] write_address = '0;
  logic [3:0][7:0] write_data = '0;
  logic            load_enable = 1'b0;
  logic [7:0]      load_address = '0;
  logic [7:0]      load_data = '0;

  logic [3:0]      rw_read_ready, rw_write_ready;
  logic [3:0][7:0] rw_read_data;
  logic [3:0][1:0] rw_state;
  logic [3:0]      ro_read_ready, ro_write_ready;
  logic [3:0][7:0] ro_read_data;
  logic [3:0][1:0] ro_state;

  int n_checks = 0;
  int n_errors = 0;
  int rise_r[4];
  int rise_w[4];

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(2), .WRITE_ENABLE(1)) u_rw (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(rw_read_ready), .read_data(rw_read_data),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .write_ready(rw_write_ready),
    .load_enable(load_enable), .load_address(load_address), .load_data(load_data),
    .state_dbg(rw_state)
  );

  mem_responder #(.ADDR_BITS(8), .DATA_BITS(8), .CHANNELS(4), .LATENCY(2), .WRITE_ENABLE(0)) u_ro (
    .clk(clk), .reset(reset),
    .read_valid(read_valid), .read_address(read_address),
    .read_ready(ro_read_ready), .read_data(ro_read_data),
    .write_valid(write_valid), .write_address(write_address), .write_data(write_data),
    .write_ready(ro_write_ready),
    .load_enable(load_enable), .load_address(load_address), .load_data(load_data),
    .state_dbg(ro_state)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Runs n cycles, recording the cycle index (1-based) at which each ready is first seen high.
  task automatic track(input int n);
    for (int c = 0; c < 4; c++) begin
      rise_r[c] = -1;
      rise_w[c] = -1;
    end
    for (int t = 1; t <= n; t++) begin
      tick();
      for (int c = 0; c < 4; c++) begin
        if (rw_read_ready[c] && rise_r[c] < 0) rise_r[c] = t;
        if (rw_write_ready[c] && rise_w[c] < 0) rise_w[c] = t;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // reset state
    tick();
    tick();
    check("reset_state", rw_state, 32'h0);
    check("reset_rready", rw_read_ready, 32'h0);
    check("reset_wready", rw_write_ready, 32'h0);
    check("reset_rdata", rw_read_data, 32'h0);
    reset = 1'b1;
    tick();

    // preload 0x5A at 0x10, ch0 reads it
    load_enable = 1'b1; load_address = 8'h10; load_data = 8'h5A;
    tick();
    load_enable = 1'b0;
    read_valid[0] = 1'b1; read_address[0] = 8'h10;
    for (int i = 0; i < 4; i++) tick();
    check("rd0_not_yet", rw_read_ready[0], 32'h0);
    tick();
    check("rd0_ready", rw_read_ready[0], 32'h1);
    check("rd0_data", rw_read_data[0], 32'h5A);
    tick();
    check("rd0_held", rw_read_ready[0], 32'h1);
    read_valid[0] = 1'b0;
    tick();
    check("rd0_dropped", rw_read_ready[0], 32'h0);
    check("rd0_idle", rw_state[0], 32'h0);

    // ch1 writes 0x33 to 0x20, then ch2 reads it back
    write_valid[1] = 1'b1; write_address[1] = 8'h20; write_data[1] = 8'h33;
    track(6);
    check("wr1_rise", rise_w[1], 32'd5);
    write_valid[1] = 1'b0;
    tick();
    read_valid[2] = 1'b1; read_address[2] = 8'h20;
    track(6);
    check("rd2_rise", rise_r[2], 32'd5);
    check("rd2_data", rw_read_data[2], 32'h33);
    read_valid[2] = 1'b0;
    tick();

    // four simultaneous reads from rr_ptr=0
    reset = 1'b0;
    tick();
    reset = 1'b1;
    read_valid = 4'hF;
    read_address[0] = 8'h10; read_address[1] = 8'h20;
    read_address[2] = 8'h10; read_address[3] = 8'h20;
    track(10);
    check("rr_rise0", rise_r[0], 32'd5);
    check("rr_rise1", rise_r[1], 32'd6);
    check("rr_rise2", rise_r[2], 32'd7);
    check("rr_rise3", rise_r[3], 32'd8);
    check("rr_data", rw_read_data, 32'h335A335A);
    read_valid = 4'h0;
    tick();
    check("rr_all_low", rw_read_ready, 32'h0);

    // ch0 write of 0xFF to 0x10: acknowledged by both, stored only by u_rw
    write_valid[0] = 1'b1; write_address[0] = 8'h10; write_data[0] = 8'hFF;
    for (int i = 0; i < 4; i++) tick();
    check("ro_wr_not_yet", ro_write_ready[0], 32'h0);
    tick();
    check("ro_wr_ready", ro_write_ready[0], 32'h1);
    check("rw_wr_ready", rw_write_ready[0], 32'h1);
    write_valid[0] = 1'b0;
    tick();
    read_valid[0] = 1'b1; read_address[0] = 8'h10;
    for (int i = 0; i < 5; i++) tick();
    check("ro_rd_ready", ro_read_ready[0], 32'h1);
    check("ro_rd_data", ro_read_data[0], 32'h5A);
    check("rw_rd_data", rw_read_data[0], 32'hFF);
    read_valid[0] = 1'b0;
    tick();

    // ch3 read+write together; load_enable stalls the grant 3 cycles
    read_valid[3] = 1'b1; read_address[3] = 8'h20;
    write_valid[3] = 1'b1; write_address[3] = 8'h30; write_data[3] = 8'hC3;
    tick();
    load_enable = 1'b1; load_address = 8'h40; load_data = 8'h77;
    tick();
    tick();
    tick();
    load_enable = 1'b0;
    check("ld_stall_queued", rw_state[3], 32'h1);
    track(6);
    check("rw3_read_rise", rise_r[3], 32'd4);
    check("rw3_no_write", rise_w[3], 32'hFFFFFFFF);
    check("rw3_read_data", rw_read_data[3], 32'h33);
    read_valid[3] = 1'b0;
    track(8);
    check("rw3_read_gone", rise_r[3], 32'hFFFFFFFF);
    check("rw3_write_rise", rise_w[3], 32'd6);
    write_valid[3] = 1'b0;
    tick();

    // rr_ptr wrapped to 0: ch0 before ch1; verify the load and the ch3 write
    read_valid[0] = 1'b1; read_address[0] = 8'h40;
    read_valid[1] = 1'b1; read_address[1] = 8'h30;
    track(7);
    check("wrap_rise0", rise_r[0], 32'd5);
    check("wrap_rise1", rise_r[1], 32'd6);
    check("load_data_rw", rw_read_data[0], 32'h77);
    check("load_data_ro", ro_read_data[0], 32'h77);
    check("ch3_write_data", rw_read_data[1], 32'hC3);
    read_valid = 4'h0;
    tick();

    // reset with ch0 BUSY and ch1 QUEUED (write of 0x99 to 0x20)
    read_valid[0] = 1'b1; read_address[0] = 8'h10;
    write_valid[1] = 1'b1; write_address[1] = 8'h20; write_data[1] = 8'h99;
    tick();
    tick();
    check("pre_rst_busy0", rw_state[0], 32'h2);
    check("pre_rst_queued1", rw_state[1], 32'h1);
    reset = 1'b0;
    tick();
    check("rst_rready", rw_read_ready, 32'h0);
    check("rst_wready", rw_write_ready, 32'h0);
    check("rst_rdata", rw_read_data, 32'h0);
    check("rst_state", rw_state, 32'h0);
    read_valid = 4'h0;
    write_valid = 4'h0;
    tick();
    reset = 1'b1;
    tick();
    read_valid[2] = 1'b1; read_address[2] = 8'h20;
    track(6);
    check("rst_rd_rise", rise_r[2], 32'd5);
    check("rst_write_dropped", rw_read_data[2], 32'h33);
    read_valid[2] = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
